nco_sine: RTL and testbench

- Parametrised successor to the up/down preloadable counter: a numerically controlled oscillator.
- A PHASE_WIDTH phase accumulator steps by a programmable increment, up or down, with preload and enable.
- Its top ADDR_WIDTH bits address a quarter-wave sine table with symmetry unfolding, producing a signed sine sample through a 2-stage registered pipeline.
- Used as the waveform source in the DSP lab datapath.

---
 rtl/nco_sine.sv | 153 +++++++++++++++
 tb/tb_nco_sine.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nco_sine.sv
// nco_sine: numerically controlled oscillator.
// A PHASE_WIDTH phase accumulator steps up or down by a zero-extended tuning
// word, with preload taking priority over enable. The top ADDR_WIDTH phase
// bits address a quarter-wave sine table that is unfolded by quadrant
// symmetry. The signed sample comes out through a 2-stage registered pipeline.
// Parameter constraints: INCR_WIDTH <= PHASE_WIDTH, 3 <= ADDR_WIDTH <= PHASE_WIDTH.
module nco_sine #(
  parameter int PHASE_WIDTH = 32,
  parameter int INCR_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DATA_WIDTH  = 16
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         enable,
  input  logic                         updn,
  input  logic                         preload,
  input  logic [PHASE_WIDTH-1:0]       pl_data,
  input  logic [INCR_WIDTH-1:0]        incr,
  output logic [PHASE_WIDTH-1:0]       phase,
  output logic                         wrap,
  output logic signed [DATA_WIDTH-1:0] sin_out,
  output logic                         valid
);

  // Table geometry: N full-wave points, M points per quadrant.
  localparam int N     = 1 << ADDR_WIDTH;
  localparam int M     = N / 4;
  localparam int IDX_W = ADDR_WIDTH - 2;
  // Magnitude width: the amplitude 2^(DATA_WIDTH-1)-1 fits without a sign bit.
  localparam int MAG_W = DATA_WIDTH - 1;

  localparam real HALF_PI = 1.57079632679489661923;
  localparam real AMP     = real'((longint'(1) << (DATA_WIDTH - 1)) - longint'(1));

  localparam logic [IDX_W:0] M_IDX = (IDX_W + 1)'(M);

  // Quarter-wave entry k: round(AMP * sin(pi/2 * k / M)). Evaluated on
  // constant arguments only, so it folds into a fixed table at elaboration.
  function automatic logic [MAG_W-1:0] quarter_entry(input int k);
    real x;
    x = AMP * $sin(HALF_PI * real'(k) / real'(M));
    // Casting real to an integral type rounds to nearest.
    return MAG_W'(longint'(x));
  endfunction

  // ---------------------------------------------------------------------------
  // Quarter-wave table, M+1 entries so the peak is stored explicitly.
  // ---------------------------------------------------------------------------
  logic [MAG_W-1:0] qtab [0:M];

  // NOTE: the table is a constant ROM, not state, so it is neither clocked nor reset.
  for (genvar k = 0; k <= M; k++) begin : g_qtab
    assign qtab[k] = quarter_entry(k);
  end

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [PHASE_WIDTH-1:0] phase_q, phase_d;
  logic                   wrap_q, wrap_d;
  logic [MAG_W-1:0]       mag1_q, mag1_d;
  logic                   neg1_q, neg1_d;
  logic [DATA_WIDTH-1:0]  sin_q, sin_d;
  logic                   prime_q, prime_d;
  logic                   valid_q, valid_d;

  // Accumulator arithmetic, kept one bit wider so carry/borrow is explicit.
  logic [PHASE_WIDTH-1:0] incr_ext;
  logic [PHASE_WIDTH:0]   sum_ext;
  logic [PHASE_WIDTH:0]   diff_ext;

  // Lookup decode.
  logic [ADDR_WIDTH-1:0]  addr;
  logic [1:0]             quad;
  logic [IDX_W-1:0]       idx;
  logic [IDX_W:0]         tab_idx;
  logic signed [DATA_WIDTH-1:0] mag_s;

  // Next phase and wrap: preload beats enable, enable beats hold.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    incr_ext = PHASE_WIDTH'(incr);
    sum_ext  = {1'b0, phase_q} + {1'b0, incr_ext};
    diff_ext = {1'b0, phase_q} - {1'b0, incr_ext};
    phase_d  = phase_q;
    wrap_d   = 1'b0;
    if (preload) begin
      phase_d = pl_data;
    end else if (enable) begin
      if (updn) begin
        // Top bit of the widened difference is the borrow.
        phase_d = diff_ext[PHASE_WIDTH-1:0];
        wrap_d  = diff_ext[PHASE_WIDTH];
      end else begin
        phase_d = sum_ext[PHASE_WIDTH-1:0];
        wrap_d  = sum_ext[PHASE_WIDTH];
      end
    end
  end

  // Stage 1 input: quadrant unfold of the registered phase into a table read.
  always_comb begin
    addr    = phase_q[PHASE_WIDTH-1 -: ADDR_WIDTH];
    quad    = addr[ADDR_WIDTH-1 -: 2];
    idx     = addr[IDX_W-1:0];
    // Odd quadrants run the quarter table backwards from the peak.
    tab_idx = quad[0] ? (M_IDX - {1'b0, idx}) : {1'b0, idx};
    mag1_d  = qtab[tab_idx];
    // Second half of the wave is the negated first half.
    neg1_d  = quad[1];
  end

  // Stage 2 input: apply the sign to the registered magnitude.
  always_comb begin
    mag_s = signed'({1'b0, mag1_q});
    sin_d = neg1_q ? -mag_s : mag_s;
  end

  // Valid shift: high from the second edge after reset release.
  always_comb begin
    prime_d = 1'b1;
    valid_d = prime_q;
  end

  // All state registers, asynchronously cleared.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q <= '0;
      wrap_q  <= 1'b0;
      mag1_q  <= '0;
      neg1_q  <= 1'b0;
      sin_q   <= '0;
      prime_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      phase_q <= phase_d;
      wrap_q  <= wrap_d;
      mag1_q  <= mag1_d;
      neg1_q  <= neg1_d;
      sin_q   <= sin_d;
      prime_q <= prime_d;
      valid_q <= valid_d;
    end
  end

  assign phase   = phase_q;
  assign wrap    = wrap_q;
  assign sin_out = signed'(sin_q);
  assign valid   = valid_q;

endmodule

// File: tb/tb_nco_sine.sv
// tb_nco_sine: directed and scoreboard checks for nco_sine with a 10-bit
// phase, 8-bit table address and 16-bit samples (a = phase[9:2]).
`timescale 1ns/1ps
module tb_nco_sine;

  localparam int PW = 10;
  localparam int IW = 10;
  localparam int AW = 8;
  localparam int DW = 16;

  logic                 clk = 1'b0;
  logic                 reset;
  logic                 enable;
  logic                 updn;
  logic                 preload;
  logic [PW-1:0]        pl_data;
  logic [IW-1:0]        incr;
  logic [PW-1:0]        phase;
  logic                 wrap;
  logic signed [DW-1:0] sin_out;
  logic                 valid;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  nco_sine #(
    .PHASE_WIDTH(PW),
    .INCR_WIDTH (IW),
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .enable (enable),
    .updn   (updn),
    .preload(preload),
    .pl_data(pl_data),
    .incr   (incr),
    .phase  (phase),
    .wrap   (wrap),
    .sin_out(sin_out),
    .valid  (valid)
  );

  // Reference sample: round(32767 * sin(2*pi*a/256)) straight from the formula.
  function automatic int sine_ref(input int a);
    real x;
    x = 32767.0 * $sin(2.0 * 3.14159265358979323846 * real'(a) / 256.0);
    return int'(x);
  endfunction

  // One rising edge, then settle to the falling edge for sampling/driving.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b0; enable = 1'b0; updn = 1'b0; preload = 1'b0;
    pl_data = '0; incr = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (phase !== 10'd0) begin errors++; $display("FAIL reset_phase got %0d want 0", phase); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL reset_wrap got %b want 0", wrap); end
    checks++; if (sin_out !== 16'sd0) begin errors++; $display("FAIL reset_sin got %0d want 0", sin_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", valid); end
    reset = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL valid_edge1 got %b want 0", valid); end
    checks++; if (phase !== 10'd0) begin errors++; $display("FAIL phase_edge1 got %0d want 0", phase); end
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL valid_edge2 got %b want 1", valid); end
    checks++; if (sin_out !== 16'sd0) begin errors++; $display("FAIL sin_edge2 got %0d want 0", sin_out); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wrap_edge2 got %b want 0", wrap); end
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL valid_edge3 got %b want 1", valid); end
  endtask

  task automatic test_sweep_up();
    int exp_sin;
    enable = 1'b1; updn = 1'b0; incr = 10'd4;
    for (int n = 1; n <= 200; n++) begin
      tick();
      checks++;
      if (phase !== 10'(4 * n)) begin
        errors++; $display("FAIL sweep_phase n=%0d got %0d want %0d", n, phase, 4 * n);
      end
      // sin_out after edge n belongs to a = n-2.
      exp_sin = 99999;
      case (n - 2)
        1:   exp_sin = 804;
        64:  exp_sin = 32767;
        128: exp_sin = 0;
        192: exp_sin = -32767;
        default: ;
      endcase
      if (exp_sin != 99999) begin
        checks++;
        if (int'(sin_out) !== exp_sin) begin
          errors++; $display("FAIL sweep_sin a=%0d got %0d want %0d", n - 2, sin_out, exp_sin);
        end
      end
    end
    enable = 1'b0;
  endtask

  task automatic test_wrap_up();
    preload = 1'b1; pl_data = 10'd1020;
    tick();
    checks++; if (phase !== 10'd1020) begin errors++; $display("FAIL wup_preload got %0d want 1020", phase); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wup_preload_wrap got %b want 0", wrap); end
    preload = 1'b0; enable = 1'b1; updn = 1'b0; incr = 10'd4;
    tick();
    checks++; if (phase !== 10'd0) begin errors++; $display("FAIL wup_phase got %0d want 0", phase); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wup_wrap got %b want 1", wrap); end
    tick();
    checks++; if (phase !== 10'd4) begin errors++; $display("FAIL wup_next_phase got %0d want 4", phase); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wup_next_wrap got %b want 0", wrap); end
    enable = 1'b0;
  endtask

  task automatic test_wrap_down();
    preload = 1'b1; pl_data = 10'd0;
    tick();
    preload = 1'b0; enable = 1'b1; updn = 1'b1; incr = 10'd4;
    tick();
    checks++; if (phase !== 10'd1020) begin errors++; $display("FAIL wdn_phase got %0d want 1020", phase); end
    checks++; if (wrap !== 1'b1) begin errors++; $display("FAIL wdn_wrap got %b want 1", wrap); end
    tick();
    checks++; if (phase !== 10'd1016) begin errors++; $display("FAIL wdn_next_phase got %0d want 1016", phase); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL wdn_next_wrap got %b want 0", wrap); end
    tick();
    checks++; if (phase !== 10'd1012) begin errors++; $display("FAIL wdn_phase3 got %0d want 1012", phase); end
    checks++; if (sin_out !== -16'sd804) begin errors++; $display("FAIL wdn_sin got %0d want -804", sin_out); end
    // Zero tuning word with enable: phase holds, no wrap.
    incr = 10'd0;
    tick();
    checks++; if (phase !== 10'd1012) begin errors++; $display("FAIL incr0_phase got %0d want 1012", phase); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL incr0_wrap got %b want 0", wrap); end
    enable = 1'b0;
  endtask

  task automatic test_preload_hold();
    preload = 1'b1; enable = 1'b1; updn = 1'b0; incr = 10'd4; pl_data = 10'd300;
    tick();
    checks++; if (phase !== 10'd300) begin errors++; $display("FAIL prio_phase got %0d want 300", phase); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL prio_wrap got %b want 0", wrap); end
    preload = 1'b0; enable = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick();
      checks++;
      if (phase !== 10'd300) begin errors++; $display("FAIL hold_phase c=%0d got %0d want 300", c, phase); end
      checks++;
      if (wrap !== 1'b0) begin errors++; $display("FAIL hold_wrap c=%0d got %b want 0", c, wrap); end
      if (c >= 2) begin
        // a = 75: round(32767*sin(2*pi*75/256)) = 31580
        checks++;
        if (sin_out !== 16'sd31580) begin errors++; $display("FAIL hold_sin c=%0d got %0d want 31580", c, sin_out); end
      end
    end
  endtask

  task automatic test_async_reset();
    enable = 1'b1; updn = 1'b0; incr = 10'd4;
    repeat (5) tick();
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    checks++; if (phase !== 10'd0) begin errors++; $display("FAIL areset_phase got %0d want 0", phase); end
    checks++; if (sin_out !== 16'sd0) begin errors++; $display("FAIL areset_sin got %0d want 0", sin_out); end
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid got %b want 0", valid); end
    checks++; if (wrap !== 1'b0) begin errors++; $display("FAIL areset_wrap got %b want 0", wrap); end
    enable = 1'b0;
    tick();
    checks++; if (phase !== 10'd0) begin errors++; $display("FAIL areset_hold_phase got %0d want 0", phase); end
    reset = 1'b1;
    tick();
    checks++; if (valid !== 1'b0) begin errors++; $display("FAIL areset_valid1 got %b want 0", valid); end
    tick();
    checks++; if (valid !== 1'b1) begin errors++; $display("FAIL areset_valid2 got %b want 1", valid); end
    checks++; if (sin_out !== 16'sd0) begin errors++; $display("FAIL areset_sin2 got %0d want 0", sin_out); end
  endtask

  task automatic test_triangle_scoreboard();
    int ph_m, hist1, hist2, inc_v, cyc;
    logic wrap_m, en_v, dir_v;
    preload = 1'b1; pl_data = 10'd500; enable = 1'b0;
    tick();
    preload = 1'b0;
    tick();
    tick();
    ph_m = 500; hist1 = 500; hist2 = 500;
    cyc = 0;
    for (int seg = 0; seg <= 6; seg++) begin
      // Segment 0: pure triangle (incr 8, toggle every 5). Segments 1..6: drifting with incr 1..6.
      inc_v = (seg == 0) ? 8 : seg;
      for (int c = 0; c < ((seg == 0) ? 200 : 300); c++) begin
        if (seg == 0) begin
          en_v  = 1'b1;
          dir_v = ((c / 5) % 2) == 1;
        end else begin
          en_v  = (c % 11) != 10;
          dir_v = ((c % 7) < 2) ^ (seg[0]);
        end
        enable = en_v; updn = dir_v; incr = 10'(inc_v);
        @(posedge clk);
        hist2 = hist1;
        hist1 = ph_m;
        wrap_m = 1'b0;
        if (en_v) begin
          if (dir_v) begin
            wrap_m = inc_v > ph_m;
            ph_m = (ph_m - inc_v + 1024) % 1024;
          end else begin
            wrap_m = (ph_m + inc_v) >= 1024;
            ph_m = (ph_m + inc_v) % 1024;
          end
        end
        @(negedge clk);
        cyc++;
        checks++;
        if (int'(phase) !== ph_m) begin
          errors++; $display("FAIL sb_phase cyc=%0d got %0d want %0d", cyc, phase, ph_m);
        end
        checks++;
        if (wrap !== wrap_m) begin
          errors++; $display("FAIL sb_wrap cyc=%0d got %b want %b", cyc, wrap, wrap_m);
        end
        checks++;
        if (int'(sin_out) !== sine_ref(hist2 / 4)) begin
          errors++; $display("FAIL sb_sin cyc=%0d got %0d want %0d", cyc, sin_out, sine_ref(hist2 / 4));
        end
      end
    end
    enable = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout at %0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_sweep_up();
    test_wrap_up();
    test_wrap_down();
    test_preload_hold();
    test_async_reset();
    test_triangle_scoreboard();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
